// File: rtl/rw_write_port_arbiter.sv
// rw_write_port_arbiter
//   Shares the single data-array write port among N_REQ write-back requesters.
//   Round-robin grant, one registered output stage, and a per-requester enable
//   mask programmed over a small register bus.
//
// Optional feature macro: RW_ARB_STATS_EN
//   Defined   : 32-bit saturating per-requester grant counters and a stall counter,
//               readable at RW_ARB_STATS_BASE+i (grant i) and RW_ARB_STATS_BASE+N_REQ
//               (stall). Any write to RW_ARB_STATS_BASE clears them all.
//   Undefined : no counters, reg_rdata is always 0.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   req_valid / req_ready     per-requester handshake (ready = accepted this cycle)
//   req_addr/req_data/req_strb  per-requester payload, slice i belongs to requester i
//   wvalid / wready           output-stage handshake into the data array
//   waddr / wdata / wstrb     registered write payload
//   reg_wvalid/waddr/wdata    register bus write channel
//   reg_arvalid/araddr        register bus read request
//   reg_rvalid/rdata          register bus read response (1-cycle latency)
module rw_write_port_arbiter #(
  parameter int unsigned       N_REQ              = 4,
  parameter int unsigned       ADDR_W             = 32,
  parameter int unsigned       DATA_W             = 512,
  parameter int unsigned       STRB_W             = DATA_W / 8,
  parameter int unsigned       REG_AW             = 32,
  parameter int unsigned       REG_DW             = 32,
  parameter logic [REG_AW-1:0] RW_ARB_ENABLE_MASK = 'h0,
  parameter logic [REG_AW-1:0] RW_ARB_STATS_BASE  = 'h10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ*STRB_W-1:0]  req_strb,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  output logic [STRB_W-1:0]        wstrb,
  input  logic                     reg_wvalid,
  input  logic [REG_AW-1:0]        reg_waddr,
  input  logic [REG_DW-1:0]        reg_wdata,
  input  logic                     reg_arvalid,
  input  logic [REG_AW-1:0]        reg_araddr,
  output logic                     reg_rvalid,
  output logic [REG_DW-1:0]        reg_rdata
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  en_mask_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  ptr_nxt;
  logic              load;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [STRB_W-1:0] sel_strb;
  logic [REG_DW-1:0] rd_data;

  assign eligible = req_valid & en_mask_q;
  assign load     = (!wvalid || wready) && (|eligible);

  // Walk from the farthest position back to rr_ptr so the nearest eligible
  // requester (circularly) is the last to overwrite and therefore wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((32'(rr_ptr_q) + 32'(k)) % N_REQ);
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  assign req_ready = load ? grant : '0;
  assign ptr_nxt   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_strb = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_addr = req_addr[k*ADDR_W +: ADDR_W];
        sel_data = req_data[k*DATA_W +: DATA_W];
        sel_strb = req_strb[k*STRB_W +: STRB_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wvalid     <= 1'b0;
      rr_ptr_q   <= '0;
      en_mask_q  <= '1;
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      if (load) begin
        wvalid   <= 1'b1;
        waddr    <= sel_addr;
        wdata    <= sel_data;
        wstrb    <= sel_strb;
        rr_ptr_q <= ptr_nxt;
      end else if (wready) begin
        wvalid   <= 1'b0;
      end
      if (reg_wvalid && (reg_waddr == RW_ARB_ENABLE_MASK)) begin
        en_mask_q <= reg_wdata[N_REQ-1:0];
      end
      reg_rvalid <= reg_arvalid;
      reg_rdata  <= reg_arvalid ? rd_data : '0;
    end
  end

`ifdef RW_ARB_STATS_EN
  logic [31:0] grant_cnt_q [N_REQ];
  logic [31:0] stall_cnt_q;
  logic        stats_clr;

  assign stats_clr = reg_wvalid && (reg_waddr == RW_ARB_STATS_BASE);

  // Clear has priority over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn || stats_clr) begin
      for (int k = 0; k < N_REQ; k++) grant_cnt_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (req_ready[k] && (grant_cnt_q[k] != '1)) grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
      end
      if (wvalid && !wready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (reg_araddr == RW_ARB_STATS_BASE + REG_AW'(k)) rd_data = REG_DW'(grant_cnt_q[k]);
    end
    if (reg_araddr == RW_ARB_STATS_BASE + REG_AW'(N_REQ)) rd_data = REG_DW'(stall_cnt_q);
  end
`else
  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_rw_write_port_arbiter.sv
module tb_rw_write_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam logic [31:0] MASK_ADDR  = 32'h0;
  localparam logic [31:0] STATS_BASE = 32'h10;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_strb;
  logic            wvalid, wready;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;
  logic            reg_wvalid, reg_arvalid, reg_rvalid;
  logic [31:0]     reg_waddr, reg_wdata, reg_araddr, reg_rdata;

  rw_write_port_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .reg_wvalid(reg_wvalid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
    .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the architectural state the spec talks about.
  int          m_ptr;
  logic [N-1:0] m_mask;
  logic        m_wvalid;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  int unsigned m_gcnt [N];
  int unsigned m_scnt;

  // Observations sampled at the negedge of the most recent step.
  logic [N-1:0]  obs_ready;
  logic          obs_wvalid, obs_rvalid;
  logic [AW-1:0] obs_waddr;
  logic [31:0]   obs_rdata;

  task automatic model_reset();
    m_ptr = 0; m_mask = '1; m_wvalid = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    m_scnt = 0;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = rand_line();
    req_strb[i*SW +: SW] = {$urandom, $urandom};
  endtask

  // One clock cycle: compare DUT against model at negedge, then advance the model.
  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    g = -1;
    if (!m_wvalid || wready) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i] && m_mask[i]) g = i;
      end
    end
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    obs_ready = req_ready; obs_wvalid = wvalid; obs_waddr = waddr;
    obs_rvalid = reg_rvalid; obs_rdata = reg_rdata;
    n_cmp++;
    if (req_ready !== exp_ready) begin
      n_err++; $display("FAIL req_ready got %b exp %b @%0t", req_ready, exp_ready, $time);
    end
    n_cmp++;
    if (wvalid !== m_wvalid) begin
      n_err++; $display("FAIL wvalid got %b exp %b @%0t", wvalid, m_wvalid, $time);
    end
    if (m_wvalid) begin
      n_cmp++;
      if (waddr !== m_waddr || wdata !== m_wdata || wstrb !== m_wstrb) begin
        n_err++;
        $display("FAIL wpayload addr got %h exp %h strb got %h exp %h @%0t",
                 waddr, m_waddr, wstrb, m_wstrb, $time);
      end
    end
    n_cmp++;
    if (reg_rvalid !== m_rvalid || (m_rvalid && reg_rdata !== m_rdata)) begin
      n_err++;
      $display("FAIL regread rvalid/rdata got %b/%h exp %b/%h @%0t",
               reg_rvalid, reg_rdata, m_rvalid, m_rdata, $time);
    end
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      m_rvalid = reg_arvalid;
      m_rdata  = '0;
`ifdef RW_ARB_STATS_EN
      if (reg_arvalid && reg_araddr >= STATS_BASE && reg_araddr < STATS_BASE + N)
        m_rdata = m_gcnt[reg_araddr - STATS_BASE];
      else if (reg_arvalid && reg_araddr == STATS_BASE + N)
        m_rdata = m_scnt;
      if (reg_wvalid && reg_waddr == STATS_BASE) begin
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
        m_scnt = 0;
      end else begin
        if (g >= 0) m_gcnt[g]++;
        if (m_wvalid && !wready) m_scnt++;
      end
`endif
      if (reg_wvalid && reg_waddr == MASK_ADDR) m_mask = reg_wdata[N-1:0];
      if (g >= 0) begin
        m_wvalid = 1'b1;
        m_waddr  = req_addr[g*AW +: AW];
        m_wdata  = req_data[g*DW +: DW];
        m_wstrb  = req_strb[g*SW +: SW];
        m_ptr    = (g + 1) % N;
      end else if (wready) begin
        m_wvalid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    reg_wvalid = 1'b1; reg_waddr = a; reg_wdata = d;
    step();
    reg_wvalid = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    reg_arvalid = 1'b1; reg_araddr = a;
    step();
    reg_arvalid = 1'b0;
    step();
    d = obs_rdata; v = obs_rvalid;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '1; wready = 1'b1;
    step();
    rstn = 1'b1;
    step();
    n_cmp++;
    if (obs_wvalid !== 1'b0 || obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL reset_state wvalid/ready got %b/%b exp 0/0001", obs_wvalid, obs_ready);
    end
    rstn = 1'b0; step(); rstn = 1'b1;
  endtask

  task automatic test_fairness();
    req_valid = '1; wready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_req(i, $urandom);
      step();
      n_cmp++;
      if (obs_ready !== (4'b0001 << (k % 4)) || (k > 0 && obs_wvalid !== 1'b1)) begin
        n_err++; $display("FAIL fairness k=%0d ready got %b exp %b wvalid %b", k, obs_ready,
                          4'b0001 << (k % 4), obs_wvalid);
      end
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010; wready = 1'b1; set_req(1, 32'h40);
    step();
    req_valid = '1; wready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) set_req(i, $urandom);
      step();
      n_cmp++;
      if (obs_waddr !== 32'h40 || obs_ready !== 4'b0000 || obs_wvalid !== 1'b1) begin
        n_err++; $display("FAIL backpressure waddr got %h exp 40 ready got %b exp 0000",
                          obs_waddr, obs_ready);
      end
    end
    wready = 1'b1;
    step();
    n_cmp++;
    if (obs_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_release ready got %b exp 0100", obs_ready);
    end
  endtask

  task automatic test_pointer();
    req_valid = '0; wready = 1'b1; step();
    req_valid = 4'b0100; set_req(2, $urandom); step();
    req_valid = '1;
    step();
    n_cmp++;
    if (obs_ready !== 4'b1000) begin
      n_err++; $display("FAIL pointer_first ready got %b exp 1000", obs_ready);
    end
    step();
    n_cmp++;
    if (obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL pointer_second ready got %b exp 0001", obs_ready);
    end
  endtask

  task automatic test_mask();
    logic [AW-1:0] a0;
    req_valid = '0; wready = 1'b1; step();
    a0 = 32'h1234_5600; set_req(0, a0);
    req_valid = 4'b0001; wready = 1'b0; step();
    req_valid = '1;
    reg_write(MASK_ADDR, 32'b1010);
    step();
    wready = 1'b1;
    step();
    n_cmp++;
    if (obs_wvalid !== 1'b1 || obs_waddr !== a0) begin
      n_err++; $display("FAIL mask_inflight waddr got %h exp %h", obs_waddr, a0);
    end
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_req(i, $urandom);
      step();
      n_cmp++;
      if (obs_ready !== 4'b0010 && obs_ready !== 4'b1000) begin
        n_err++; $display("FAIL mask_grant ready got %b exp 0010 or 1000", obs_ready);
      end
    end
    reg_write(MASK_ADDR, 32'h0);
    step();
    n_cmp++;
    if (obs_ready !== 4'b0000) begin
      n_err++; $display("FAIL mask_zero ready got %b exp 0000", obs_ready);
    end
    reg_write(MASK_ADDR, 32'hF);
  endtask

  task automatic test_reset_midflight();
    reg_write(MASK_ADDR, 32'b1010);
    req_valid = 4'b0010; wready = 1'b0; set_req(1, $urandom);
    step(); step();
    rstn = 1'b0; step(); rstn = 1'b1;
    req_valid = '1; wready = 1'b1;
    step();
    n_cmp++;
    if (obs_wvalid !== 1'b0 || obs_ready !== 4'b0001) begin
      n_err++; $display("FAIL reset_mid wvalid/ready got %b/%b exp 0/0001", obs_wvalid, obs_ready);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic v;
    req_valid = '0; wready = 1'b1; step();
    reg_read(MASK_ADDR, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_err++; $display("FAIL reg_mask_read rvalid/rdata got %b/%h exp 1/0", v, d);
    end
`ifdef RW_ARB_STATS_EN
    reg_write(STATS_BASE, 32'h0);
    req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) begin set_req(0, $urandom); step(); end
    req_valid = '0; wready = 1'b0;
    repeat (3) step();
    wready = 1'b1; step();
    reg_read(STATS_BASE, d, v);
    n_cmp++;
    if (d !== 32'd10) begin n_err++; $display("FAIL stats_grant0 got %0d exp 10", d); end
    reg_read(STATS_BASE + 4, d, v);
    n_cmp++;
    if (d !== 32'd3) begin n_err++; $display("FAIL stats_stall got %0d exp 3", d); end
    reg_write(STATS_BASE, 32'h0);
    reg_read(STATS_BASE, d, v);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL stats_clr_grant got %0d exp 0", d); end
    reg_read(STATS_BASE + 4, d, v);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL stats_clr_stall got %0d exp 0", d); end
`else
    reg_read(STATS_BASE + 4, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_err++; $display("FAIL reg_nostats_read rvalid/rdata got %b/%h exp 1/0", v, d);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom_range(0, 15));
      wready    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_req(i, $urandom);
      reg_wvalid  = ($urandom_range(0, 19) == 0);
      reg_waddr   = ($urandom_range(0, 3) == 0) ? STATS_BASE : MASK_ADDR;
      reg_wdata   = $urandom_range(1, 15);
      reg_arvalid = ($urandom_range(0, 3) == 0);
      reg_araddr  = STATS_BASE + 32'($urandom_range(0, 5));
      step();
    end
    reg_wvalid = 1'b0; reg_arvalid = 1'b0;
    reg_write(MASK_ADDR, 32'hF);
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; wready = 1'b0;
    req_addr = '0; req_data = '0; req_strb = '0;
    reg_wvalid = 1'b0; reg_waddr = '0; reg_wdata = '0;
    reg_arvalid = 1'b0; reg_araddr = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    test_reset();
    test_fairness();
    test_backpressure();
    test_pointer();
    test_mask();
    test_reset_midflight();
    test_regs();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
